// File: rtl/mem_arbiter4.sv
// rtl/mem_arbiter4.sv - four-requester round-robin arbiter for a shared memory port
module mem_arbiter4 #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] last_q, last_d;
   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;

   // Round-robin search: last+1, last+2, last+3, last. Result {found, index}.
   function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] last);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (mask[idx]) begin
            r = {1'b1, idx};
         end
      end
      return r;
   endfunction

   logic [2:0] win;
   logic [3:0] elig;
   logic       at_limit;
   logic       aborted;
   logic       release_now;

   // Next-state logic: grant selection, release detection and hand-off
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      last_d      = last_q;
      hold_d      = hold_q;
      timeout_d   = 1'b0;
      elig        = req;
      win         = 3'b000;
      at_limit    = (hold_q == HOLD_LIMIT);
      aborted     = ~req[sel_q];
      release_now = 1'b0;

      case (state_q)
         IDLE: begin
            win = pick(req, last_q);
            if (win[2]) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win[1:0];
               sel_d   = win[1:0];
               last_d  = win[1:0];
               hold_d  = 8'd0;
            end
         end
         GRANT: begin
            release_now = done | aborted | at_limit;
            if (release_now) begin
               // On done the holder stays eligible; it sits last in the search
               // order, so it only wins again when nobody else is asking.
               if (!done) begin
                  elig = req & ~(4'b0001 << sel_q);
               end
               timeout_d = ~done & ~aborted & at_limit;
               win       = pick(elig, last_q);
               if (win[2]) begin
                  gnt_d  = 4'b0001 << win[1:0];
                  sel_d  = win[1:0];
                  last_d = win[1:0];
                  hold_d = 8'd0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  hold_d  = 8'd0;
               end
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         sel_q     <= 2'b00;
         last_q    <= 2'b11;
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign busy    = (state_q == GRANT);
   assign timeout = timeout_q;

endmodule
